// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Contents:
//   ADDR_W/DATA_W/BE_W   - memory bus widths
//   REQ_CORE/REQ_DBG     - requester indices (core LSU, debug/loader)
//   arb_state_t          - arbiter FSM states
//   mem_req_t            - captured request payload
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wren;
        logic [BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way grant logic for mem_arbiter.
// Ports:
//   req[1:0]    - request vector (bit index = requester index)
//   last_grant  - index of the requester granted most recently
//   gnt[1:0]    - one-hot grant, zero when nothing is requested
// Build option: MEM_ARBITER_FIXED_PRIO_EN makes requester 0 win every tie
// and leaves last_grant unused; otherwise ties go to the requester that was
// not granted last.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // A lone request always wins; only a tie needs a decision.
    always_comb begin
        gnt = req;
        if (req[REQ_CORE] && req[REQ_DBG]) begin
            gnt = 2'b00;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            gnt[REQ_CORE] = 1'b1;
`else
            if (last_grant == REQ_DBG) begin
                gnt[REQ_CORE] = 1'b1;
            end else begin
                gnt[REQ_DBG] = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a core LSU (requester 0) and a debug/loader port (requester 1)
// onto a single-ported synchronous memory, one transaction at a time.
// Handshake at edge T -> o_mem_en in cycle T+1 -> rvld pulse in cycle T+2.
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_reqN_vld/addr/wdata/wren/be - request from requester N
//   o_reqN_rdy              - combinational accept (winner in IDLE only)
//   o_reqN_rvld/rdata       - one-cycle response pulse and load data
//   o_mem_*                 - memory strobe, address, data, write, byte enables
//   i_mem_rdata             - memory read data, valid the cycle after o_mem_en
//   o_busy                  - high whenever the FSM is not IDLE
// Build option: MEM_ARBITER_FIXED_PRIO_EN selects fixed priority (requester 0
// wins ties) instead of round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0_vld,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    input  logic              i_req0_wren,
    input  logic [BE_W-1:0]   i_req0_be,
    output logic              o_req0_rdy,
    output logic              o_req0_rvld,
    output logic [DATA_W-1:0] o_req0_rdata,

    input  logic              i_req1_vld,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    input  logic              i_req1_wren,
    input  logic [BE_W-1:0]   i_req1_be,
    output logic              o_req1_rdy,
    output logic              o_req1_rvld,
    output logic [DATA_W-1:0] o_req1_rdata,

    output logic              o_mem_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_wren,
    output logic [BE_W-1:0]   o_mem_be,
    input  logic [DATA_W-1:0] i_mem_rdata,

    output logic              o_busy
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    mem_req_t          cap_q;
    mem_req_t          win_req;
    logic              cap_idx_q;
    logic              last_grant_q;
    logic [1:0]        req_vld;
    logic [1:0]        gnt;
    logic [1:0]        rdy;
    logic              hs;
    logic              mem_en_q;
    logic              mem_wren_q;
    logic [1:0]        rvld_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] resp_data;

    assign req_vld = {i_req1_vld, i_req0_vld};

    // Grant decision for the current IDLE cycle.
    rr_arbiter2 u_rr_arbiter2 (
        .req        (req_vld),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

    // Payload of whichever requester is granted.
    always_comb begin
        win_req.addr  = gnt[REQ_DBG] ? i_req1_addr  : i_req0_addr;
        win_req.wdata = gnt[REQ_DBG] ? i_req1_wdata : i_req0_wdata;
        win_req.wren  = gnt[REQ_DBG] ? i_req1_wren  : i_req0_wren;
        win_req.be    = gnt[REQ_DBG] ? i_req1_be    : i_req0_be;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ready; gnt is already qualified by vld, so rdy implies
    // a handshake at the coming edge.
    always_comb begin
        state_d = state_q;
        rdy     = 2'b00;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_rst) begin
                    rdy = gnt;
                end
                hs = |rdy;
                if (|req_vld) begin
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, memory strobe, response pulse and held load data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cap_q        <= '0;
            cap_idx_q    <= REQ_CORE;
            last_grant_q <= REQ_DBG;
            mem_en_q     <= 1'b0;
            mem_wren_q   <= 1'b0;
            rvld_q       <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            mem_en_q   <= hs;
            mem_wren_q <= hs & win_req.wren;
            if (state_q == ACCESS) begin
                rvld_q <= (cap_idx_q == REQ_DBG) ? 2'b10 : 2'b01;
            end else begin
                rvld_q <= 2'b00;
            end
            if (hs) begin
                cap_q        <= win_req;
                cap_idx_q    <= gnt[REQ_DBG];
                last_grant_q <= gnt[REQ_DBG];
            end
            if (rvld_q[REQ_CORE]) begin
                rdata0_q <= resp_data;
            end
            if (rvld_q[REQ_DBG]) begin
                rdata1_q <= resp_data;
            end
        end
    end

    // Memory data arrives in the RESP cycle itself, so it is forwarded
    // combinationally there and held in a register afterwards.
    assign resp_data = cap_q.wren ? '0 : i_mem_rdata;

    assign o_req0_rdy   = rdy[REQ_CORE];
    assign o_req1_rdy   = rdy[REQ_DBG];
    assign o_req0_rvld  = rvld_q[REQ_CORE];
    assign o_req1_rvld  = rvld_q[REQ_DBG];
    assign o_req0_rdata = rvld_q[REQ_CORE] ? resp_data : rdata0_q;
    assign o_req1_rdata = rvld_q[REQ_DBG]  ? resp_data : rdata1_q;

    assign o_mem_en    = mem_en_q;
    assign o_mem_wren  = mem_wren_q;
    assign o_mem_addr  = cap_q.addr;
    assign o_mem_wdata = cap_q.wdata;
    assign o_mem_be    = cap_q.be;

    assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req0_vld, i_req0_wren, i_req1_vld, i_req1_wren;
    logic [31:0] i_req0_addr, i_req0_wdata, i_req1_addr, i_req1_wdata;
    logic [3:0]  i_req0_be, i_req1_be;
    logic        o_req0_rdy, o_req0_rvld, o_req1_rdy, o_req1_rvld;
    logic [31:0] o_req0_rdata, o_req1_rdata;
    logic        o_mem_en, o_mem_wren, o_busy;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic [31:0] i_mem_rdata;

    mem_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_vld(i_req0_vld), .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
        .i_req0_wren(i_req0_wren), .i_req0_be(i_req0_be), .o_req0_rdy(o_req0_rdy),
        .o_req0_rvld(o_req0_rvld), .o_req0_rdata(o_req0_rdata),
        .i_req1_vld(i_req1_vld), .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
        .i_req1_wren(i_req1_wren), .i_req1_be(i_req1_be), .o_req1_rdy(o_req1_rdy),
        .o_req1_rvld(o_req1_rvld), .o_req1_rdata(o_req1_rdata),
        .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wren(o_mem_wren), .o_mem_be(o_mem_be), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference: one transaction occupies three cycles,
    // so the arbiter is free again at grant cycle + 3.
    int          cyc;
    int          free_cyc;
    int          acc_cyc;
    int          resp_cyc;
    logic        m_last;
    logic [31:0] m_addr, m_wdata, m_resp;
    logic [3:0]  m_be;
    logic        m_wren;
    logic        m_idx;
    logic [31:0] m_hold [2];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] stub_mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] stub_read(input logic [31:0] a);
        return stub_mem.exists(a) ? stub_mem[a] : dflt(a);
    endfunction

    // Memory stub: answers a strobe during its own cycle so data is valid next cycle.
    always @(negedge i_clk) begin
        if (o_mem_en === 1'b1) begin
            if (o_mem_wren === 1'b1) begin
                stub_mem[o_mem_addr] = merge(stub_read(o_mem_addr), o_mem_wdata, o_mem_be);
                i_mem_rdata = $urandom;
            end else begin
                i_mem_rdata = stub_read(o_mem_addr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_last   = 1'b1;
        free_cyc = cyc + 1;
        acc_cyc  = -1;
        resp_cyc = -1;
        m_addr   = '0;
        m_wdata  = '0;
        m_be     = '0;
        m_wren   = 1'b0;
        m_idx    = 1'b0;
        m_hold[0] = '0;
        m_hold[1] = '0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic w, input logic [3:0] b);
        if (n == 0) begin
            i_req0_vld = v; i_req0_addr = a; i_req0_wdata = d; i_req0_wren = w; i_req0_be = b;
        end else begin
            i_req1_vld = v; i_req1_addr = a; i_req1_wdata = d; i_req1_wren = w; i_req1_be = b;
        end
    endtask

    // One clock cycle: compare every output against the model, then step
    // the model across the edge. Returns the granted requester or -1.
    task automatic tick(output int hs);
        logic [1:0]  exp_rdy, exp_rv;
        logic        idle, exp_en;
        logic [31:0] exp_rd0, exp_rd1;
        int          w;
        hs = -1;
        w  = -1;
        #2;
        idle    = (cyc >= free_cyc);
        exp_rdy = 2'b00;
        if (idle && !i_rst) begin
            if (i_req0_vld && i_req1_vld) w = (FIXED || m_last) ? 0 : 1;
            else if (i_req0_vld)          w = 0;
            else if (i_req1_vld)          w = 1;
            if (w >= 0) exp_rdy[w] = 1'b1;
        end
        n_checks++;
        if ({o_req1_rdy, o_req0_rdy} !== exp_rdy) begin
            n_fail++;
            $display("FAIL rdy cyc=%0d got=%b exp=%b", cyc, {o_req1_rdy, o_req0_rdy}, exp_rdy);
        end
        n_checks++;
        if (o_busy !== !idle) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, !idle);
        end
        exp_en = (cyc == acc_cyc);
        n_checks++;
        if (o_mem_en !== exp_en || o_mem_wren !== (exp_en & m_wren) || o_mem_addr !== m_addr ||
            o_mem_wdata !== m_wdata || o_mem_be !== m_be) begin
            n_fail++;
            $display("FAIL mem cyc=%0d got en=%b we=%b a=%h d=%h be=%h exp en=%b we=%b a=%h d=%h be=%h",
                     cyc, o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be,
                     exp_en, exp_en & m_wren, m_addr, m_wdata, m_be);
        end
        exp_rv  = (cyc == resp_cyc) ? (m_idx ? 2'b10 : 2'b01) : 2'b00;
        exp_rd0 = exp_rv[0] ? m_resp : m_hold[0];
        exp_rd1 = exp_rv[1] ? m_resp : m_hold[1];
        n_checks++;
        if ({o_req1_rvld, o_req0_rvld} !== exp_rv || o_req0_rdata !== exp_rd0 ||
            o_req1_rdata !== exp_rd1) begin
            n_fail++;
            $display("FAIL resp cyc=%0d got rvld=%b rd0=%h rd1=%h exp rvld=%b rd0=%h rd1=%h",
                     cyc, {o_req1_rvld, o_req0_rvld}, o_req0_rdata, o_req1_rdata,
                     exp_rv, exp_rd0, exp_rd1);
        end
        if (exp_rv[0]) m_hold[0] = m_resp;
        if (exp_rv[1]) m_hold[1] = m_resp;
        if (i_rst) begin
            model_reset();
        end else if (w >= 0) begin
            m_addr  = (w == 1) ? i_req1_addr  : i_req0_addr;
            m_wdata = (w == 1) ? i_req1_wdata : i_req0_wdata;
            m_wren  = (w == 1) ? i_req1_wren  : i_req0_wren;
            m_be    = (w == 1) ? i_req1_be    : i_req0_be;
            m_idx   = (w == 1);
            m_last  = (w == 1);
            m_resp  = m_wren ? 32'h0 : ref_read(m_addr);
            if (m_wren) ref_mem[m_addr] = merge(ref_read(m_addr), m_wdata, m_be);
            acc_cyc  = cyc + 1;
            resp_cyc = cyc + 2;
            free_cyc = cyc + 3;
            hs = w;
        end
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
        #1;
    endtask

    task automatic drain();
        int hs;
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        repeat (3) tick(hs);
    endtask

    task automatic test_reset();
        int hs;
        i_rst = 1'b1;
        set_req(0, 1'b1, $urandom, $urandom, 1'b0, 4'hF);
        set_req(1, 1'b1, $urandom, $urandom, 1'b1, 4'hF);
        #1;
        n_checks++;
        if (o_req0_rdy !== 1'b0 || o_req1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy got=%b%b exp=00", o_req1_rdy, o_req0_rdy);
        end
        tick(hs);
        tick(hs);
        i_rst = 1'b0;
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        n_checks++;
        if (o_busy !== 1'b0 || o_mem_en !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_be !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b en=%b a=%h be=%h exp 0", o_busy, o_mem_en,
                     o_mem_addr, o_mem_be);
        end
        n_checks++;
        if (o_req0_rvld !== 1'b0 || o_req1_rvld !== 1'b0 || o_req0_rdata !== 32'h0 ||
            o_req1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp got rv=%b%b rd0=%h rd1=%h exp 0", o_req1_rvld, o_req0_rvld,
                     o_req0_rdata, o_req1_rdata);
        end
    endtask

    task automatic test_single_read();
        int hs;
        ref_mem[32'h10]  = 32'hDEAD_BEEF;
        stub_mem[32'h10] = 32'hDEAD_BEEF;
        set_req(0, 1'b1, 32'h10, $urandom, 1'b0, 4'hF);
        tick(hs);
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        n_checks++;
        if (o_mem_en !== 1'b1 || o_mem_addr !== 32'h10 || o_mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_access got en=%b a=%h we=%b exp en=1 a=10 we=0",
                     o_mem_en, o_mem_addr, o_mem_wren);
        end
        tick(hs);
        n_checks++;
        if (o_req0_rvld !== 1'b1 || o_req0_rdata !== 32'hDEAD_BEEF || o_req1_rvld !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_resp got rv0=%b rd0=%h rv1=%b exp rv0=1 rd0=deadbeef rv1=0",
                     o_req0_rvld, o_req0_rdata, o_req1_rvld);
        end
        tick(hs);
        n_checks++;
        if (o_req0_rvld !== 1'b0 || o_req0_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_read_hold got rv0=%b rd0=%h exp rv0=0 rd0=deadbeef",
                     o_req0_rvld, o_req0_rdata);
        end
        drain();
    endtask

    task automatic test_write();
        int hs;
        set_req(1, 1'b1, 32'h20, 32'h1234_5678, 1'b1, 4'hF);
        tick(hs);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        n_checks++;
        if (o_mem_en !== 1'b1 || o_mem_wren !== 1'b1 || o_mem_addr !== 32'h20 ||
            o_mem_wdata !== 32'h1234_5678 || o_mem_be !== 4'hF) begin
            n_fail++;
            $display("FAIL write_access got en=%b we=%b a=%h d=%h be=%h exp 1 1 20 12345678 f",
                     o_mem_en, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_be);
        end
        tick(hs);
        n_checks++;
        if (o_req1_rvld !== 1'b1 || o_req1_rdata !== 32'h0 || o_req0_rvld !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ack got rv1=%b rd1=%h rv0=%b exp rv1=1 rd1=0 rv0=0",
                     o_req1_rvld, o_req1_rdata, o_req0_rvld);
        end
        drain();
    endtask

    task automatic test_tie_after_reset();
        int hs;
        int g_idx [$];
        int g_cyc [$];
        i_rst = 1'b1;
        tick(hs);
        i_rst = 1'b0;
        set_req(0, 1'b1, 32'h0, $urandom, 1'b0, 4'hF);
        set_req(1, 1'b1, 32'h4, $urandom, 1'b0, 4'hF);
        for (int i = 0; i < 10 && g_idx.size() < 2; i++) begin
            #1;
            if (o_req0_rdy === 1'b1 && i_req0_vld) begin g_idx.push_back(0); g_cyc.push_back(i); end
            if (o_req1_rdy === 1'b1 && i_req1_vld) begin g_idx.push_back(1); g_cyc.push_back(i); end
            tick(hs);
            if (hs == 0) set_req(0, 1'b0, '0, '0, 1'b0, '0);
            if (hs == 1) set_req(1, 1'b0, '0, '0, 1'b0, '0);
        end
        n_checks++;
        if (g_idx.size() != 2) begin
            n_fail++;
            $display("FAIL tie_count got=%0d exp=2", g_idx.size());
        end else begin
            n_checks++;
            if (g_idx[0] != 0 || g_idx[1] != 1 || g_cyc[1] - g_cyc[0] != 3) begin
                n_fail++;
                $display("FAIL tie_order got=%0d,%0d gap=%0d exp=0,1 gap=3", g_idx[0], g_idx[1],
                         g_cyc[1] - g_cyc[0]);
            end
        end
        drain();
    endtask

    task automatic test_contention();
        int hs;
        int g_idx [$];
        int exp_g [4];
        i_rst = 1'b1;
        tick(hs);
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_g[k] = FIXED ? 0 : (k % 2);
        set_req(0, 1'b1, $urandom, $urandom, 1'($urandom), 4'($urandom));
        set_req(1, 1'b1, $urandom, $urandom, 1'($urandom), 4'($urandom));
        for (int i = 0; i < 12; i++) begin
            #1;
            if (o_req0_rdy === 1'b1) g_idx.push_back(0);
            if (o_req1_rdy === 1'b1) g_idx.push_back(1);
            tick(hs);
            if (hs >= 0) set_req(hs, 1'b1, $urandom, $urandom, 1'($urandom), 4'($urandom));
        end
        n_checks++;
        if (g_idx.size() != 4) begin
            n_fail++;
            $display("FAIL contention_count got=%0d exp=4", g_idx.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (g_idx[k] != exp_g[k]) begin
                    n_fail++;
                    $display("FAIL contention_grant%0d got=%0d exp=%0d", k, g_idx[k], exp_g[k]);
                end
            end
        end
        drain();
    endtask

    task automatic test_reset_in_access();
        int hs;
        set_req(0, 1'b1, $urandom, $urandom, 1'b0, 4'hF);
        tick(hs);
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        i_rst = 1'b1;
        tick(hs);
        i_rst = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_mem_en !== 1'b0 || o_req0_rvld !== 1'b0 || o_req1_rvld !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access_after got busy=%b en=%b rv=%b%b exp 0", o_busy, o_mem_en,
                     o_req1_rvld, o_req0_rvld);
        end
        tick(hs);
        n_checks++;
        if (o_req0_rvld !== 1'b0 || o_req1_rvld !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access_norvld got rv=%b%b exp 00", o_req1_rvld, o_req0_rvld);
        end
        set_req(0, 1'b1, $urandom, $urandom, 1'b0, 4'hF);
        set_req(1, 1'b1, $urandom, $urandom, 1'b0, 4'hF);
        #1;
        n_checks++;
        if (o_req0_rdy !== 1'b1 || o_req1_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_access_tie got rdy=%b%b exp 01", o_req1_rdy, o_req0_rdy);
        end
        tick(hs);
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        drain();
    endtask

    task automatic test_late_arrival();
        int hs;
        set_req(0, 1'b1, $urandom, $urandom, 1'b0, 4'hF);
        tick(hs);
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        tick(hs);
        set_req(1, 1'b1, 32'h0000_0104, 32'hCAFE_0001, 1'b1, 4'h3);
        #1;
        n_checks++;
        if (o_req1_rdy !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL late_wait got rdy1=%b busy=%b exp rdy1=0 busy=1", o_req1_rdy, o_busy);
        end
        tick(hs);
        #1;
        n_checks++;
        if (o_req1_rdy !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL late_accept got rdy1=%b busy=%b exp rdy1=1 busy=0", o_req1_rdy, o_busy);
        end
        tick(hs);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        tick(hs);
        n_checks++;
        if (o_req1_rvld !== 1'b1 || o_req1_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL late_ack got rv1=%b rd1=%h exp rv1=1 rd1=0", o_req1_rvld, o_req1_rdata);
        end
        drain();
    endtask

    task automatic test_random();
        int hs;
        for (int i = 0; i < 400; i++) begin
            i_rst = ($urandom_range(0, 99) == 0);
            for (int n = 0; n < 2; n++) begin
                if ((n == 0 ? i_req0_vld : i_req1_vld) == 1'b0 && $urandom_range(0, 9) < 4) begin
                    set_req(n, 1'b1,
                            ($urandom_range(0, 3) == 0) ? 32'($urandom) : {26'h0, 4'($urandom), 2'b00},
                            $urandom, 1'($urandom), 4'($urandom));
                end
            end
            tick(hs);
            if (hs >= 0) begin
                if ($urandom_range(0, 1) == 0) set_req(hs, 1'b0, '0, '0, 1'b0, '0);
                else set_req(hs, 1'b1, {26'h0, 4'($urandom), 2'b00}, $urandom, 1'($urandom),
                             4'($urandom));
            end
        end
        i_rst = 1'b0;
        drain();
    endtask

    initial begin
        i_mem_rdata = '0;
        i_rst = 1'b1;
        set_req(0, 1'b0, '0, '0, 1'b0, '0);
        set_req(1, 1'b0, '0, '0, 1'b0, '0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        i_rst = 1'b0;
        cyc = 0;
        model_reset();
        free_cyc = 0;

        test_reset();
        test_single_read();
        test_write();
        test_tie_after_reset();
        test_contention();
        test_reset_in_access();
        test_late_arrival();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
